hazard_byp_ctrl: RTL
====================

# hazard_byp_ctrl

Pipeline hazard and bypass controller for the 5-stage CPU. It tracks destination registers of in-flight instructions and generates the bypass selects that drive the RF source bypass muxes in EX. It detects load-use hazards and inserts a one-cycle bubble. It also distributes the per-stage stall signals, folding in data-memory stalls and branch flushes.

## Interface
Parameters:
- RF_AW, 4, register-file address width; register 0 is hardwired zero and is never bypassed.
- CNT_W, 16, width of the load-use stall performance counter.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  asynchronous, active-high reset.
- p0_addr_ID  input  RF_AW  source-0 register of the instruction in ID.
- p1_addr_ID  input  RF_AW  source-1 register of the instruction in ID.
- re0_ID, re1_ID  input  1  instruction in ID reads port 0 / port 1.
- dst_addr_ID  input  RF_AW  destination register of the instruction in ID.
- we_ID  input  1  instruction in ID writes the RF.
- ld_ID  input  1  instruction in ID is a load (result available only after DM).
- dm_stall  input  1  data memory not ready; freezes the whole pipeline.
- flush  input  1  taken branch/jump resolved in EX; squashes IF and ID.
- byp0_EX, byp0_DM, byp1_EX, byp1_DM  output  1 each  registered bypass selects, valid while the consumer is in EX.
- stall_IF_ID, stall_ID_EX, stall_EX_DM, stall_DM_WB  output  1 each  stage register hold enables.
- bubble_ID_EX  output  1  ID_EX loads a NOP (clear we/ld/mem controls) this cycle.
- lu_stall_cnt  output  CNT_W  saturating count of load-use bubbles inserted.

## Operation
- There is a shadow pipeline of {dst, we, ld} at three stages: S1 (ID_EX), S2 (EX_DM), S3 (DM_WB).
- Shadow advance:
  - S1 ← ID fields, or zeros on bubble/flush.
  - S2 ← S1.
  - S3 ← S2.
- Match condition: match(x, S) = re_x_ID & S.we & (S.dst == px_addr_ID) & (px_addr_ID != 0).
- Bypass next-state, per port x in {0,1}:
  - bypx_EX_nxt = match(x, S1).
  - bypx_DM_nxt = match(x, S2).
  - Both may be 1; the datapath gives EX priority.
- The RF is write-before-read, so no bypass is needed for an S3 producer.
- Load-use hazard: lu = (match(0, S1) | match(1, S1)) & S1.ld & !flush.
- Stall outputs:
  - dm_stall = 1: all four stalls = 1, bubble = 0, all state holds, and the counter does not increment.
  - else if flush: all stalls = 0, bubble = 1. The ID instruction is squashed, so lu is ignored.
  - else if lu: stall_IF_ID = 1, others 0, bubble = 1.
  - else: all 0.
- On a bubble, the bypass registers load 0 and S1 loads zeros.
- lu_stall_cnt increments on each cycle with lu & !dm_stall, and saturates at all-ones.
- There is no explicit FSM. The pipeline state is the shadow registers.

## Timing
- Stall and bubble outputs are combinational from the current ID inputs, S1, dm_stall and flush.
- Bypass outputs are registered. They are computed in ID and appear the cycle after the instruction leaves ID, aligned with it in EX.
- Load-use sequence:
  - Cycle N: lu = 1, bubble.
  - Cycle N+1: the consumer is re-evaluated with S1 = bubble and S2 = load, so byp_DM = 1.
  - Cycle N+2: the consumer is in EX with byp_DM asserted.
  - Total penalty is exactly 1 cycle.
- Back-to-back producers (ALU in S1, ALU in S2, same dst): both byp_EX and byp_DM are 1, and the datapath picks EX.
- dm_stall during a pending lu: everything holds. Once dm_stall drops, lu is re-evaluated against unchanged S1 and still inserts exactly one bubble.
- Reset (asynchronous, any cycle, including mid-stall): the following clear to 0 immediately:
  - all shadow stages
  - all byp* outputs
  - lu_stall_cnt

  Stall and bubble outputs are then 0 unless inputs demand otherwise.

## Test plan
- ALU forward: ADD R3 in ID, then SUB reading R3 on p0 next cycle → byp0_EX = 1 while SUB is in EX; byp0_DM = 0; no stall.
- Distance-2 forward: producer writes R5, one unrelated instruction, then consumer reads R5 on p1 → byp1_DM = 1, byp1_EX = 0.
- R0 and no-read filtering:
  - Producer with dst = 0, consumer reads R0 → all byp = 0.
  - Consumer with re1_ID = 0 whose address matches → byp1 = 0.
- Load-use: LW R2, then ADD reading R2 → one cycle with stall_IF_ID = 1 and bubble_ID_EX = 1, then byp_DM = 1 in the consumer's EX; lu_stall_cnt 0 → 1.
- Flush vs load-use: lu condition present with flush = 1 → stall_IF_ID = 0, bubble = 1, counter unchanged.
- dm_stall and reset:
  - dm_stall held 3 cycles during lu → all stalls = 1 and byp/shadow/counter frozen; afterwards exactly one bubble.
  - rst asserted mid-sequence → byp* and counter read 0 before the next clk edge.

Source files
------------

// File: rtl/hazard_byp_ctrl.sv
// hazard_byp_ctrl: hazard detection and bypass control for the 5-stage pipeline.
//
// Tracks the destination of in-flight instructions in a small shadow pipeline.
// Produces registered bypass selects for the EX source muxes. Detects load-use
// hazards and inserts a single bubble. Distributes per-stage stall enables,
// folding in data-memory stalls and branch flushes.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   p0_addr_ID, p1_addr_ID   source registers of the instruction in ID
//   re0_ID, re1_ID           ID instruction reads source port 0 / 1
//   dst_addr_ID, we_ID       ID instruction destination / writes RF
//   ld_ID                    ID instruction is a load
//   dm_stall                 data memory not ready, freezes the whole pipeline
//   flush                    taken branch/jump in EX, squashes IF and ID
//   byp{0,1}_{EX,DM}         registered bypass selects, valid for the EX consumer
//   stall_*                  stage register hold enables
//   bubble_ID_EX             ID_EX loads a NOP this cycle
//   lu_stall_cnt             saturating count of load-use bubbles
module hazard_byp_ctrl #(
  parameter int unsigned RF_AW = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [RF_AW-1:0] p0_addr_ID,
  input  logic [RF_AW-1:0] p1_addr_ID,
  input  logic             re0_ID,
  input  logic             re1_ID,
  input  logic [RF_AW-1:0] dst_addr_ID,
  input  logic             we_ID,
  input  logic             ld_ID,
  input  logic             dm_stall,
  input  logic             flush,
  output logic             byp0_EX,
  output logic             byp0_DM,
  output logic             byp1_EX,
  output logic             byp1_DM,
  output logic             stall_IF_ID,
  output logic             stall_ID_EX,
  output logic             stall_EX_DM,
  output logic             stall_DM_WB,
  output logic             bubble_ID_EX,
  output logic [CNT_W-1:0] lu_stall_cnt
);

  // Shadow of the ID_EX (S1) and EX_DM (S2) stages. The DM_WB stage needs no
  // shadow: the RF is write-before-read, so a WB producer is never bypassed
  // and its fields would never be read. Only S1 needs the load flag, since a
  // load in S2 already forwards from DM.
  logic [RF_AW-1:0] s1_dst_q, s2_dst_q;
  logic             s1_we_q, s1_ld_q, s2_we_q;

  logic m0_s1, m1_s1, m0_s2, m1_s2;
  logic lu;

  always_comb begin
    m0_s1 = re0_ID & s1_we_q & (s1_dst_q == p0_addr_ID) & (p0_addr_ID != '0);
    m1_s1 = re1_ID & s1_we_q & (s1_dst_q == p1_addr_ID) & (p1_addr_ID != '0);
    m0_s2 = re0_ID & s2_we_q & (s2_dst_q == p0_addr_ID) & (p0_addr_ID != '0);
    m1_s2 = re1_ID & s2_we_q & (s2_dst_q == p1_addr_ID) & (p1_addr_ID != '0);
    // A squashed ID instruction cannot cause a load-use stall.
    lu    = (m0_s1 | m1_s1) & s1_ld_q & ~flush;
  end

  always_comb begin
    stall_IF_ID  = 1'b0;
    stall_ID_EX  = 1'b0;
    stall_EX_DM  = 1'b0;
    stall_DM_WB  = 1'b0;
    bubble_ID_EX = 1'b0;
    if (dm_stall) begin
      stall_IF_ID = 1'b1;
      stall_ID_EX = 1'b1;
      stall_EX_DM = 1'b1;
      stall_DM_WB = 1'b1;
    end else if (flush) begin
      bubble_ID_EX = 1'b1;
    end else if (lu) begin
      stall_IF_ID  = 1'b1;
      bubble_ID_EX = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_dst_q     <= '0;
      s1_we_q      <= 1'b0;
      s1_ld_q      <= 1'b0;
      s2_dst_q     <= '0;
      s2_we_q      <= 1'b0;
      byp0_EX      <= 1'b0;
      byp0_DM      <= 1'b0;
      byp1_EX      <= 1'b0;
      byp1_DM      <= 1'b0;
      lu_stall_cnt <= '0;
    end else if (!dm_stall) begin
      if (bubble_ID_EX) begin
        s1_dst_q <= '0;
        s1_we_q  <= 1'b0;
        s1_ld_q  <= 1'b0;
        byp0_EX  <= 1'b0;
        byp0_DM  <= 1'b0;
        byp1_EX  <= 1'b0;
        byp1_DM  <= 1'b0;
      end else begin
        s1_dst_q <= dst_addr_ID;
        s1_we_q  <= we_ID;
        s1_ld_q  <= ld_ID;
        byp0_EX  <= m0_s1;
        byp0_DM  <= m0_s2;
        byp1_EX  <= m1_s1;
        byp1_DM  <= m1_s2;
      end
      s2_dst_q <= s1_dst_q;
      s2_we_q  <= s1_we_q;
      if (lu && (lu_stall_cnt != '1)) begin
        lu_stall_cnt <= lu_stall_cnt + CNT_W'(1);
      end
    end
  end

endmodule
